// File: rtl/eyeriss_mem_pkg.sv
// Shared types and default widths for the scratch-RAM access blocks.
package eyeriss_mem_pkg;

    localparam int unsigned AW_DEF     = 16;
    localparam int unsigned DW_DEF     = 16;
    localparam int unsigned LW_DEF     = 16;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO that catches RAM read data and presents the oldest word.
module rd_skid_fifo #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    logic [1:0][DW-1:0] mem_q, mem_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; storage cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= {2{{DW{1'b0}}}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

    rd_skid_fifo_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .count (count_q)
    );

endmodule

// Protocol checks for rd_skid_fifo: no overflow, no underflow.
module rd_skid_fifo_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic       pop,
    input logic [1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == 2'd2)));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (count == 2'd0)));

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator: turns (addr, len) commands into consecutive RAM reads
// and a back-pressurable word stream at up to one word per cycle.
module ram_burst_reader
    import eyeriss_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    rd_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] issued_q, issued_d;
    logic [LW-1:0] popped_q, popped_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    // rd_s1: address on the RAM bus this cycle; rd_s2: its data is on mem_dout.
    logic          rd_s1_q, rd_s1_d;
    logic          rd_s2_q, rd_s2_d;
    logic          done_q, done_d;

    logic          issue_s;
    logic          pop_s;
    logic          push_s;
    logic          last_beat_s;
    logic [2:0]    outstanding_s;
    logic [1:0]    fifo_count;
    logic [DW-1:0] fifo_head;
    logic          fifo_full;
    logic          fifo_empty;

    // FSM, address/length capture, issue credit and beat counting.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
        issue_s    = 1'b0;

        pop_s  = !fifo_empty && out_ready;
        // Data stage that finds the FIFO full waits; mem_addr is still its
        // address (no issue can have happened since), so mem_dout keeps the word.
        push_s = rd_s2_q && (!fifo_full || pop_s);
        // Words already claimed: FIFO contents plus both read pipeline stages.
        outstanding_s = {1'b0, fifo_count} + {2'b00, rd_s1_q} + {2'b00, rd_s2_q}
                      - {2'b00, pop_s};
        last_beat_s   = pop_s && (popped_q == (len_q - LW'(1)));

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    len_d    = cmd_len;
                    popped_d = {LW{1'b0}};
                    if (cmd_len == {LW{1'b0}}) begin
                        issued_d = {LW{1'b0}};
                        done_d   = 1'b1;
                    end else begin
                        // First read goes out on the accepting edge.
                        state_d    = RUN;
                        issue_s    = 1'b1;
                        mem_addr_d = cmd_addr;
                        issued_d   = LW'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Three outstanding words cover the two-cycle read pipeline and
                // still fit: at most two in the FIFO plus one held at the RAM.
                if ((issued_q != len_q) && (outstanding_s < 3'd3)) begin
                    issue_s    = 1'b1;
                    mem_addr_d = addr_q + AW'(issued_q);
                    issued_d   = issued_q + LW'(1);
                end else begin
                    issue_s = 1'b0;
                end
                if (pop_s) begin
                    popped_d = popped_q + LW'(1);
                end else begin
                    popped_d = popped_q;
                end
                if (last_beat_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_s1_d = issue_s;
        if (rd_s2_q && !push_s) begin
            rd_s2_d = 1'b1;
        end else begin
            rd_s2_d = rd_s1_q;
        end
    end

    // Control and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= {AW{1'b0}};
            len_q      <= {LW{1'b0}};
            issued_q   <= {LW{1'b0}};
            popped_q   <= {LW{1'b0}};
            mem_addr_q <= {AW{1'b0}};
            rd_s1_q    <= 1'b0;
            rd_s2_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            mem_addr_q <= mem_addr_d;
            rd_s1_q    <= rd_s1_d;
            rd_s2_q    <= rd_s2_d;
            done_q     <= done_d;
        end
    end

    rd_skid_fifo #(.DW(DW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (mem_dout),
        .pop       (pop_s),
        .count     (fifo_count),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign mem_addr  = mem_addr_q;
    assign mem_we    = 1'b0;
    assign mem_din   = {DW{1'b0}};
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head;
    assign out_last  = !fifo_empty && (popped_q == (len_q - LW'(1)));
    // Zero-length bursts pulse from the register; real bursts pulse with the last beat.
    assign done      = done_q || last_beat_s;

endmodule
